// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding, bit-timing helpers
// and parity-sense constants. The parity logic is built only when UART_RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam logic PARITY_SENSE_EVEN = 1'b0;
  localparam logic PARITY_SENSE_ODD  = 1'b1;

  function automatic int clks_per_bit(input int clock_rate, input int baud_rate);
    return clock_rate / baud_rate;
  endfunction

  function automatic int half_bit(input int clock_rate, input int baud_rate);
    return clks_per_bit(clock_rate, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with push/pop and full/empty flags. Pointers carry one extra
// wrap bit so that full and empty can be told apart without a separate counter.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok, pop_ok;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A push into a full FIFO still succeeds when the head is popped in the same cycle.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding a sync_fifo with a valid/ready output side.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop bits.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_RATE = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 frame_err,
  output logic                 parity_err,
  output logic                 valid,
  input  logic                 ready,
  output logic                 overflow,
  output logic                 busy
);

  localparam int CPB   = clks_per_bit(CLOCK_RATE, BAUD_RATE);
  localparam int HALF  = half_bit(CLOCK_RATE, BAUD_RATE);
  localparam int CNT_W = $clog2(CPB);
`ifdef UART_RX_PARITY_EN
  localparam int   ENTRY_W = DATA_BITS + 2;
  localparam logic SENSE   = (PARITY_ODD != 0) ? PARITY_SENSE_ODD : PARITY_SENSE_EVEN;
`else
  localparam int   ENTRY_W = DATA_BITS + 1;
`endif

  logic                 sync1_q, sync2_q, prev_q, rx_s;
  rx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 ferr_q, ferr_d;
  logic                 overflow_q, overflow_d;
  logic                 push, pop;
  logic [ENTRY_W-1:0]   wdata, rdata;
  logic                 fifo_full, fifo_empty;
`ifdef UART_RX_PARITY_EN
  logic                 perr_q, perr_d;
`endif

  assign rx_s = sync2_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    ferr_d   = ferr_q;
    push     = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr_d   = perr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        // Needs a high-to-low transition, so a held break never retriggers.
        if (prev_q && !rx_s) begin
          state_d = ST_START;
          bit_d   = '0;
          ferr_d  = 1'b0;
`ifdef UART_RX_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      ST_START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = '0;
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d   = '0;
          perr_d  = ((^shift_q) ^ rx_s) != SENSE;
          state_d = ST_STOP;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == CNT_W'(CPB - 1)) begin
          cnt_d = '0;
          if (!rx_s) ferr_d = 1'b1;
          if (bit_q == 4'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  assign wdata = {perr_q, ferr_d, shift_q};
`else
  assign wdata = {ferr_d, shift_q};
`endif

  assign pop        = valid & ready;
  assign overflow_d = push & fifo_full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      prev_q     <= 1'b1;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      ferr_q     <= 1'b0;
      overflow_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q     <= 1'b0;
`endif
    end else begin
      sync1_q    <= rx;
      sync2_q    <= sync1_q;
      prev_q     <= sync2_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      ferr_q     <= ferr_d;
      overflow_q <= overflow_d;
`ifdef UART_RX_PARITY_EN
      perr_q     <= perr_d;
`endif
    end
  end

  sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Outputs read as zero while the FIFO is empty, so reset leaves every output at 0.
  assign valid     = ~fifo_empty;
  assign data      = valid ? rdata[DATA_BITS-1:0] : '0;
  assign frame_err = valid & rdata[DATA_BITS];
`ifdef UART_RX_PARITY_EN
  assign parity_err = valid & rdata[DATA_BITS+1];
`else
  assign parity_err = 1'b0;
`endif
  assign overflow  = overflow_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: serial frames are driven bit by bit, the expected characters are
// queued by a capacity-aware FIFO model and a negedge monitor checks every accepted pop.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int CLOCK_RATE = 100000000;
  localparam int BAUD_RATE  = 1000000;
  localparam int CPB        = 100;
  localparam int DATA_BITS  = 8;
  localparam int DEPTH      = 4;
  localparam int PARITY_ODD = 0;
  localparam int W          = DATA_BITS + 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 rx = 1'b1;
  logic                 ready = 1'b0;
  logic [DATA_BITS-1:0] data;
  logic                 frame_err, parity_err, valid, overflow, busy;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int exp_ovf = 0;
  int ovf_seen = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rise_cyc = 0;
  logic rand_ready_en = 1'b0;

  uart_rx_fifo #(
    .CLOCK_RATE (CLOCK_RATE),
    .BAUD_RATE  (BAUD_RATE),
    .DATA_BITS  (DATA_BITS),
    .STOP_BITS  (1),
    .FIFO_DEPTH (DEPTH),
    .PARITY_ODD (PARITY_ODD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data       (data),
    .frame_err  (frame_err),
    .parity_err (parity_err),
    .valid      (valid),
    .ready      (ready),
    .overflow   (overflow),
    .busy       (busy)
  );

  // Clock and cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Reference model of one received character: {parity_err, frame_err, data}.
  function automatic logic [W-1:0] model_entry(input logic [7:0] d, input logic stop_lvl,
                                               input logic pbit);
    logic perr;
    perr = 1'b0;
`ifdef UART_RX_PARITY_EN
    perr = (((^d) ^ pbit) != (PARITY_ODD != 0));
`else
    perr = 1'b0 & pbit;
`endif
    return {perr, ~stop_lvl, d};
  endfunction

  // A character finds room unless DEPTH entries are already waiting with no consumer.
  task automatic expect_char(input logic [W-1:0] e);
    if (exp_q.size() >= DEPTH && !ready) exp_ovf++;
    else exp_q.push_back(e);
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_lvl, input logic par_flip,
                            input int gap_bits);
    logic pbit;
    pbit = (^d) ^ (PARITY_ODD != 0) ^ par_flip;
    expect_char(model_entry(d, stop_lvl, pbit));
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DATA_BITS; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(pbit);
`endif
    send_bit(stop_lvl);
    for (int i = 0; i < gap_bits; i++) send_bit(1'b1);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 ready = v;
  endtask

  task automatic wait_drain(input string nm);
    int b;
    b = 0;
    while (exp_q.size() != 0 && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check(nm, exp_q.size(), 0);
  endtask

  // Random consumer, active only while rand_ready_en is set
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (rand_ready_en) ready = 1'($urandom_range(0, 1));
    end
  end

  // Scoreboard monitor
  logic         valid_prev = 1'b0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] held = '0;
  always @(negedge clk) begin
    logic [W-1:0] got, e;
    got = {parity_err, frame_err, data};
    if (rst) begin
      valid_prev   = 1'b0;
      hold_pending = 1'b0;
    end else begin
      if (overflow) ovf_seen++;
      if (valid && !valid_prev) rise_cyc = cyc;
      if (hold_pending && valid) check("hold_stable", got, held);
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_char: got 0x%0h with no character outstanding (cycle %0d)",
                   got, cyc);
        end else begin
          e = exp_q.pop_front();
          check("char", got, e);
        end
      end
      hold_pending = valid && !ready;
      held         = got;
      valid_prev   = valid;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] d;
    logic       stop_ok, flip;
    int         gap, lat;

    // Reset state
    rst = 1'b1; rx = 1'b1; ready = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_parity_err", parity_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);

    // Single character and latency from start edge to valid
    set_ready(1'b1);
    @(negedge clk);
    send_frame(8'hA5, 1'b1, 1'b0, 2);
    lat = rise_cyc - start_cyc;
    check("latency_window", (lat >= 950 && lat <= 958), 1);
    wait_drain("drain_a5");

    // Back-to-back frames with a stalled consumer: fifth character overflows
    set_ready(1'b0);
    @(negedge clk);
    send_frame(8'h00, 1'b1, 1'b0, 0);
    send_frame(8'hFF, 1'b1, 1'b0, 0);
    send_frame(8'h3C, 1'b1, 1'b0, 0);
    send_frame(8'h81, 1'b1, 1'b0, 0);
    send_frame(8'h55, 1'b1, 1'b0, 2);
    check("ovf_once", ovf_seen, 1);
    check("held_count", exp_q.size(), 4);
    check("valid_while_full", valid, 1);
    set_ready(1'b1);
    wait_drain("drain_overflow");

    // Short glitch is a false start
    @(negedge clk);
    rx = 1'b0;
    repeat (30) @(negedge clk);
    rx = 1'b1;
    check("glitch_busy_hi", busy, 1);
    repeat (50) @(negedge clk);
    check("glitch_busy_lo", busy, 0);
    repeat (200) @(negedge clk);
    check("glitch_no_valid", valid, 0);

    // Framing error then a clean character
    send_frame(8'h5A, 1'b0, 1'b0, 2);
    send_frame(8'h12, 1'b1, 1'b0, 2);
    wait_drain("drain_ferr");

    // Break: one all-zero framing-error character, then wait for line high
    expect_char(model_entry(8'h00, 1'b0, 1'b0));
    rx = 1'b0;
    repeat (15 * CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_frame(8'h33, 1'b1, 1'b0, 2);
    wait_drain("drain_break");

    // Reset in the middle of data bit 4 aborts the frame
    rx = 1'b0;
    repeat (5 * CPB + CPB / 2) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1; rx = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", valid, 0);
    #1 rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    check("midrst_no_char", valid, 0);
    send_frame(8'hC3, 1'b1, 1'b0, 2);
    wait_drain("drain_c3");

`ifdef UART_RX_PARITY_EN
    // Parity sense: correct parity bit, then a flipped one
    send_frame(8'h07, 1'b1, 1'b0, 2);
    send_frame(8'h07, 1'b1, 1'b1, 2);
    wait_drain("drain_parity");
`endif

    // Randomised characters, stop errors, gaps and consumer stalls
    rand_ready_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      d       = 8'($urandom_range(0, 255));
      stop_ok = ($urandom_range(0, 3) != 0);
      flip    = 1'($urandom_range(0, 1));
      gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      send_frame(d, stop_ok, flip, gap);
    end
    rand_ready_en = 1'b0;
    set_ready(1'b1);
    wait_drain("drain_random");

    repeat (10) @(negedge clk);
    check("ovf_total", ovf_seen, exp_ovf);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
